// File: rtl/sram_arb_pkg.sv
// Shared types and default sizes for the SRAM port arbiter.
//   state_e : top-level sequencing state (array clear vs normal service)
//   grant_e : which requester owns the macro this cycle
package sram_arb_pkg;

    localparam int unsigned DEF_ADDR_W = 8;
    localparam int unsigned DEF_DATA_W = 64;
    localparam int unsigned DEF_MASK_W = 8;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_RD   = 2'd1,
        GNT_WR   = 2'd2
    } grant_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a last-grant register.
//   clock, reset_n : clock and asynchronous active-low reset
//   en             : grants are only issued while high
//   req[1:0]       : request vector, req[0] = read side, req[1] = write side
//   gnt[1:0]       : one-hot grant (all zero when disabled or idle)
// After reset the last grant is taken to be req[1], so req[0] wins the first tie.
module rr_arb2 (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // 1: the most recent grant went to req[1]
    logic last_q;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                gnt = last_q ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= 1'b1;
        end else if (gnt != 2'b00) begin
            last_q <= gnt[1];
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Sequencer for a single-port RW0-style SRAM macro shared by one reader and one writer.
// Zero-fills the array after reset and on flush, then serves valid/ready requests with
// round-robin priority, one access per cycle, 1-cycle read latency.
//   clock, reset_n                 : clock, asynchronous active-low reset
//   flush_req, init_done           : re-zero request pulse / high when not clearing
//   rd_valid, rd_ready, rd_addr    : read request channel
//   rsp_valid, rsp_ready, rsp_data : read response channel (data straight from macro)
//   wr_valid, wr_ready, wr_addr, wr_mask, wr_data : write request channel
//   mem_addr, mem_en, mem_wmode, mem_wmask, mem_wdata, mem_rdata : macro RW0 port
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned MASK_W = DEF_MASK_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              flush_req,
    output logic              init_done,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [MASK_W-1:0] wr_mask,
    input  logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en,
    output logic              mem_wmode,
    output logic [MASK_W-1:0] mem_wmask,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              flush_pend_q, flush_pend_d;
    logic              rsp_free;
    logic              flush_go;
    logic              arb_en;
    logic [1:0]        gnt;
    grant_e            gnt_sel;

    // The macro read path is combinational from the array, so nothing may touch it
    // while a response is waiting to be taken.
    assign rsp_free = !rsp_valid_q || rsp_ready;
    assign flush_go = (state_q == RUN) && flush_pend_q && rsp_free;
    assign arb_en   = (state_q == RUN) && !flush_pend_q && rsp_free;

    rr_arb2 u_rr_arb2 (
        .clock   (clock),
        .reset_n (reset_n),
        .en      (arb_en),
        .req     ({wr_valid, rd_valid}),
        .gnt     (gnt)
    );

    always_comb begin
        unique case (gnt)
            2'b01:   gnt_sel = GNT_RD;
            2'b10:   gnt_sel = GNT_WR;
            default: gnt_sel = GNT_NONE;
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            CLEAR: if (clr_cnt_q == LAST_ADDR) state_d = RUN;
            RUN:   if (flush_go) state_d = CLEAR;
        endcase
    end

    // Clear counter, flush latch and response flag
    always_comb begin
        clr_cnt_d    = clr_cnt_q;
        flush_pend_d = flush_pend_q;
        rsp_valid_d  = rsp_valid_q;
        if (state_q == CLEAR) begin
            // flush_req is ignored here; the running clear already covers it
            clr_cnt_d = (clr_cnt_q == LAST_ADDR) ? '0 : clr_cnt_q + ADDR_W'(1);
        end else begin
            if (flush_go) begin
                flush_pend_d = 1'b0;
                clr_cnt_d    = '0;
            end else if (flush_req) begin
                flush_pend_d = 1'b1;
            end
            if (gnt_sel == GNT_RD) begin
                rsp_valid_d = 1'b1;
            end else if (rsp_ready) begin
                rsp_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clr_cnt_q    <= '0;
            flush_pend_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
        end else begin
            clr_cnt_q    <= clr_cnt_d;
            flush_pend_q <= flush_pend_d;
            rsp_valid_q  <= rsp_valid_d;
        end
    end

    // Outputs
    always_comb begin
        mem_en    = 1'b0;
        mem_wmode = 1'b0;
        mem_addr  = '0;
        mem_wmask = '0;
        mem_wdata = '0;
        unique case (state_q)
            CLEAR: begin
                // Gate with reset so the macro is idle while reset is held
                mem_en    = reset_n;
                mem_wmode = 1'b1;
                mem_addr  = clr_cnt_q;
                mem_wmask = '1;
            end
            RUN: begin
                unique case (gnt_sel)
                    GNT_RD: begin
                        mem_en   = 1'b1;
                        mem_addr = rd_addr;
                    end
                    GNT_WR: begin
                        mem_en    = 1'b1;
                        mem_wmode = 1'b1;
                        mem_addr  = wr_addr;
                        mem_wmask = wr_mask;
                        mem_wdata = wr_data;
                    end
                    default: begin
                    end
                endcase
            end
        endcase
    end

    assign rd_ready  = (gnt_sel == GNT_RD);
    assign wr_ready  = (gnt_sel == GNT_WR);
    assign init_done = (state_q == RUN);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = mem_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter with a behavioural SRAM macro and reference memory.
module tb_sram_port_arbiter;

    localparam int unsigned AW    = 8;
    localparam int unsigned DW    = 64;
    localparam int unsigned MW    = 8;
    localparam int unsigned DEPTH = 256;

    logic          clock = 1'b0;
    logic          reset_n = 1'b1;
    logic          flush_req = 1'b0;
    logic          init_done;
    logic          rd_valid = 1'b0;
    logic          rd_ready;
    logic [AW-1:0] rd_addr = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_data;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [AW-1:0] wr_addr = '0;
    logic [MW-1:0] wr_mask = '0;
    logic [DW-1:0] wr_data = '0;
    logic [AW-1:0] mem_addr;
    logic          mem_en;
    logic          mem_wmode;
    logic [MW-1:0] mem_wmask;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int n_checks = 0;
    int n_fails  = 0;

    sram_port_arbiter #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .MASK_W (MW)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush_req (flush_req),
        .init_done (init_done),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_addr   (rd_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_mask   (wr_mask),
        .wr_data   (wr_data),
        .mem_addr  (mem_addr),
        .mem_en    (mem_en),
        .mem_wmode (mem_wmode),
        .mem_wmask (mem_wmask),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial forever #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d",
                 n_checks, n_fails);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                            input logic [MW-1:0] m);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < MW; b++) begin
            if (m[b]) r[b*8 +: 8] = d[b*8 +: 8];
        end
        return r;
    endfunction

    // Behavioural RW0 macro: registered read address, contents never reset
    logic [DW-1:0] sram [DEPTH];
    logic [AW-1:0] sram_raddr = '0;
    assign mem_rdata = sram[sram_raddr];

    initial begin
        for (int i = 0; i < DEPTH; i++) sram[i] = {$urandom(), $urandom()};
        forever begin
            @(posedge clock);
            if (mem_en && mem_wmode) sram[mem_addr] <= merge(sram[mem_addr], mem_wdata, mem_wmask);
            else if (mem_en) sram_raddr <= mem_addr;
        end
    end

    // Reference model and scoreboard
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_q [$];
    bit            m_run, m_last_wr, m_fp, m_rsp;
    int            m_clr;

    initial begin
        bit run_now, allowed, go_flush, exp_rd, exp_wr;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                chk("rst_init_done", 64'(init_done), 64'(1'b0));
                chk("rst_rsp_valid", 64'(rsp_valid), 64'(1'b0));
                chk("rst_rd_ready", 64'(rd_ready), 64'(1'b0));
                chk("rst_wr_ready", 64'(wr_ready), 64'(1'b0));
                chk("rst_mem_en", 64'(mem_en), 64'(1'b0));
                m_run = 0; m_clr = 0; m_last_wr = 1; m_fp = 0; m_rsp = 0;
                exp_q.delete();
                for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
            end else begin
                chk("init_done", 64'(init_done), 64'(m_run));
                chk("rsp_valid", 64'(rsp_valid), 64'(m_rsp));
                if (m_rsp && exp_q.size() > 0) begin
                    chk("rsp_data", 64'(rsp_data), 64'(exp_q[0]));
                    if (rsp_ready) void'(exp_q.pop_front());
                end
                run_now  = m_run;
                go_flush = m_run && m_fp && (!m_rsp || rsp_ready);
                allowed  = m_run && !m_fp && (!m_rsp || rsp_ready);
                exp_rd   = allowed && rd_valid && (!wr_valid || m_last_wr);
                exp_wr   = allowed && wr_valid && !exp_rd;
                chk("rd_ready", 64'(rd_ready), 64'(exp_rd));
                chk("wr_ready", 64'(wr_ready), 64'(exp_wr));
                if (!run_now) begin
                    chk("clr_en", 64'(mem_en), 64'(1'b1));
                    chk("clr_wmode", 64'(mem_wmode), 64'(1'b1));
                    chk("clr_addr", 64'(mem_addr), 64'(m_clr));
                    chk("clr_mask", 64'(mem_wmask), 64'(8'hFF));
                    chk("clr_data", 64'(mem_wdata), 64'(0));
                    if (m_clr == DEPTH - 1) begin
                        m_clr = 0;
                        m_run = 1;
                    end else begin
                        m_clr++;
                    end
                end else if (exp_rd) begin
                    chk("rd_mem_en", 64'(mem_en), 64'(1'b1));
                    chk("rd_mem_wmode", 64'(mem_wmode), 64'(1'b0));
                    chk("rd_mem_addr", 64'(mem_addr), 64'(rd_addr));
                    exp_q.push_back(ref_mem[rd_addr]);
                    m_last_wr = 0;
                    m_rsp = 1;
                end else if (exp_wr) begin
                    chk("wr_mem_en", 64'(mem_en), 64'(1'b1));
                    chk("wr_mem_wmode", 64'(mem_wmode), 64'(1'b1));
                    chk("wr_mem_addr", 64'(mem_addr), 64'(wr_addr));
                    chk("wr_mem_mask", 64'(mem_wmask), 64'(wr_mask));
                    chk("wr_mem_data", 64'(mem_wdata), 64'(wr_data));
                    ref_mem[wr_addr] = merge(ref_mem[wr_addr], wr_data, wr_mask);
                    m_last_wr = 1;
                    if (rsp_ready) m_rsp = 0;
                end else begin
                    chk("idle_mem_en", 64'(mem_en), 64'(1'b0));
                    if (rsp_ready) m_rsp = 0;
                end
                if (go_flush) begin
                    m_run = 0; m_clr = 0; m_fp = 0;
                    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
                end else if (run_now && flush_req) begin
                    m_fp = 1;
                end
            end
        end
    end

    // Stimulus helpers: inputs change 1 time unit after the rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [MW-1:0] m,
                            input logic [DW-1:0] d);
        bit done;
        done = 0;
        wr_valid = 1; wr_addr = a; wr_mask = m; wr_data = d;
        for (int i = 0; i < 1000 && !done; i++) begin
            @(negedge clock);
            done = wr_ready;
            tick();
        end
        wr_valid = 0;
        if (!done) chk("wr_grant_timeout", 64'(done), 64'(1'b1));
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        bit done;
        done = 0;
        rd_valid = 1; rd_addr = a;
        for (int i = 0; i < 1000 && !done; i++) begin
            @(negedge clock);
            done = rd_ready;
            tick();
        end
        rd_valid = 0;
        if (!done) chk("rd_grant_timeout", 64'(done), 64'(1'b1));
    endtask

    task automatic wait_init(input logic v, output int n);
        n = 0;
        while (n < 2000) begin
            @(negedge clock);
            if (init_done == v) break;
            n++;
        end
        if (n >= 2000) chk("init_done_timeout", 64'(init_done), 64'(v));
        tick();
    endtask

    initial begin
        int n;
        logic [5:0] rd_pat, wr_pat;
        #1 reset_n = 0;
        repeat (3) @(posedge clock);
        #1 reset_n = 1;
        wait_init(1'b1, n);
        chk("clear_cycles", 64'(n), 64'(DEPTH));

        rsp_ready = 1;
        do_read(8'h7F);
        @(negedge clock);
        chk("read_after_clear", 64'(rsp_data), 64'(0));
        tick();

        do_write(8'h10, 8'hFF, 64'h0123456789ABCDEF);
        do_write(8'h10, 8'h01, '1);
        do_read(8'h10);
        @(negedge clock);
        chk("rmw_rsp_valid", 64'(rsp_valid), 64'(1'b1));
        chk("rmw_data", 64'(rsp_data), 64'h0123456789ABCDFF);
        tick();

        // Contention: a write first so the next tie goes to the reader
        do_write(8'h30, 8'hFF, 64'hA5A5_5A5A_0F0F_F0F0);
        rd_valid = 1; rd_addr = 8'h30;
        wr_valid = 1; wr_addr = 8'h31; wr_mask = 8'hFF; wr_data = 64'h1111_2222_3333_4444;
        rd_pat = '0; wr_pat = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            rd_pat = {rd_pat[4:0], rd_ready};
            wr_pat = {wr_pat[4:0], wr_ready};
            tick();
        end
        rd_valid = 0; wr_valid = 0;
        chk("rr_rd_pattern", 64'(rd_pat), 64'(6'b101010));
        chk("rr_wr_pattern", 64'(wr_pat), 64'(6'b010101));

        // Stalled response blocks the writer
        rsp_ready = 0;
        do_read(8'h20);
        wr_valid = 1; wr_addr = 8'h21; wr_mask = 8'hF0; wr_data = 64'hCAFE_F00D_DEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("stall_wr_ready", 64'(wr_ready), 64'(1'b0));
            chk("stall_rsp_valid", 64'(rsp_valid), 64'(1'b1));
            tick();
        end
        rsp_ready = 1;
        @(negedge clock);
        chk("unstall_wr_ready", 64'(wr_ready), 64'(1'b1));
        tick();
        wr_valid = 0;

        // Flush while a response is stalled
        do_write(8'h10, 8'hFF, 64'hDEAD_BEEF_0BAD_F00D);
        rsp_ready = 0;
        do_read(8'h10);
        flush_req = 1;
        tick();
        flush_req = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("flush_wait_init", 64'(init_done), 64'(1'b1));
            tick();
        end
        rsp_ready = 1;
        wait_init(1'b0, n);
        wait_init(1'b1, n);
        chk("flush_clear_cycles", 64'(n), 64'(DEPTH - 1));
        do_read(8'h10);
        @(negedge clock);
        chk("read_after_flush", 64'(rsp_data), 64'(0));
        tick();

        // Reset mid-transaction: response dropped asynchronously
        rsp_ready = 0;
        do_read(8'h05);
        chk("pre_reset_rsp_valid", 64'(rsp_valid), 64'(1'b1));
        reset_n = 0;
        #1;
        chk("async_rsp_drop", 64'(rsp_valid), 64'(1'b0));
        chk("async_init_drop", 64'(init_done), 64'(1'b0));
        tick();
        reset_n = 1;
        rsp_ready = 1;

        // Reset at clr_cnt == 100
        repeat (100) tick();
        reset_n = 0;
        #1;
        chk("midclr_init_done", 64'(init_done), 64'(1'b0));
        chk("midclr_mem_en", 64'(mem_en), 64'(1'b0));
        chk("midclr_rsp_valid", 64'(rsp_valid), 64'(1'b0));
        tick();
        reset_n = 1;
        wait_init(1'b1, n);
        chk("midclr_restart_cycles", 64'(n), 64'(DEPTH));

        // Randomized traffic over a small address window
        for (int c = 0; c < 3000; c++) begin
            rd_valid  = 1'($urandom_range(0, 1));
            rd_addr   = AW'($urandom_range(0, 15));
            wr_valid  = 1'($urandom_range(0, 1));
            wr_addr   = AW'($urandom_range(0, 15));
            wr_mask   = MW'($urandom());
            wr_data   = {$urandom(), $urandom()};
            rsp_ready = ($urandom_range(0, 3) != 0);
            flush_req = ($urandom_range(0, 599) == 0);
            tick();
        end
        rd_valid = 0; wr_valid = 0; flush_req = 0; rsp_ready = 1;
        wait_init(1'b1, n);
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
